// File: rtl/dispatch_if.sv
// ---------------------------------------------------------------------------
// dispatch_if
// Bundles the decoded-pair handshake and the reservation-station free counts
// that the dispatch controller looks at each cycle.
//
// Signals:
//   in_val    [1:0]       per-slot valid of the decoded pair (slot 0 older)
//   in_class  [1:0][1:0]  per-slot class: 0=ALU 1=MEM 2=BR 3=NONE
//   in_rdy                pair consumed this cycle
//   grant     [1:0]       slot i written into its class station this cycle
//   alu_free  [1:0]       free ALU station entries (0..3)
//   mem_free  [1:0]       free MEM station entries (0..3)
//   br_free   [1:0]       free BR station entries (0..3)
//
// Modports:
//   master  upstream side (drives the pair and free counts)
//   slave   dispatch controller side
// ---------------------------------------------------------------------------
interface dispatch_if;
    logic [1:0]      in_val;
    logic [1:0][1:0] in_class;
    logic            in_rdy;
    logic [1:0]      grant;
    logic [1:0]      alu_free;
    logic [1:0]      mem_free;
    logic [1:0]      br_free;

    modport master (
        output in_val, in_class, alu_free, mem_free, br_free,
        input  in_rdy, grant
    );

    modport slave (
        input  in_val, in_class, alu_free, mem_free, br_free,
        output in_rdy, grant
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// dispatch_ctrl
// Two-wide in-order dispatch controller. Each cycle it decides which slots
// of the decoded pair can be written into their class reservation station.
// Slot 1 may only go once slot 0 has gone (or needs no entry); if slot 0
// goes alone the controller remembers that in the HALF state so the pair is
// not dispatched twice while upstream holds it stable.
//
// Parameters:
//   PIPE_WIDTH  dispatch slots per cycle (only 2 is supported)
//   CNT_BITS    width of the saturating stall counter
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   flush      synchronous pipeline flush
//   bus        dispatch_if.slave (pair handshake, grants, free counts)
//   stall_cnt  cycles in which a valid pair was not fully consumed
// ---------------------------------------------------------------------------
module dispatch_ctrl #(
    parameter int PIPE_WIDTH = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    dispatch_if.slave           bus,
    output logic [CNT_BITS-1:0] stall_cnt
);

    // PAIR: nothing of the current pair dispatched yet.
    // HALF: slot 0 already went, only slot 1 is outstanding.
    localparam logic [0:0] ST_PAIR = 1'b0;
    localparam logic [0:0] ST_HALF = 1'b1;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_MEM  = 2'd1;
    localparam logic [1:0] CLS_BR   = 2'd2;
    localparam logic [1:0] CLS_NONE = 2'd3;

    logic [0:0]            r_state;
    logic [0:0]            w_nextState;
    logic [CNT_BITS-1:0]   r_stallCnt;

    logic [1:0]            w_cls0;
    logic [1:0]            w_cls1;
    logic [1:0]            w_free0;
    logic [1:0]            w_free1;
    logic [1:0]            w_need1;
    logic                  w_req0;
    logic                  w_req1;
    logic                  w_done0;
    logic                  w_done1;
    logic                  w_g0;
    logic                  w_g1;
    logic                  w_ok0;
    logic                  w_ok1;
    logic                  w_inRdy;
    logic [PIPE_WIDTH-1:0] w_grant;

    // Free count of the station a given class targets; NONE targets nothing.
    function automatic logic [1:0] freeFor(
        input logic [1:0] cls,
        input logic [1:0] aluFree,
        input logic [1:0] memFree,
        input logic [1:0] brFree
    );
        logic [1:0] res;
        res = 2'd0;
        case (cls)
            CLS_ALU: res = aluFree;
            CLS_MEM: res = memFree;
            CLS_BR:  res = brFree;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Per-slot decode: a slot needs an entry when valid and not NONE; it is
    // done (consumes nothing) when invalid or a valid NONE.
    always_comb begin
        w_cls0  = bus.in_class[0];
        w_cls1  = bus.in_class[1];
        w_free0 = freeFor(w_cls0, bus.alu_free, bus.mem_free, bus.br_free);
        w_free1 = freeFor(w_cls1, bus.alu_free, bus.mem_free, bus.br_free);
        w_req0  = bus.in_val[0] && (w_cls0 != CLS_NONE);
        w_req1  = bus.in_val[1] && (w_cls1 != CLS_NONE);
        w_done0 = !bus.in_val[0] || (w_cls0 == CLS_NONE);
        w_done1 = !bus.in_val[1] || (w_cls1 == CLS_NONE);
    end

    // Grant / ready decision. Slot 1 only becomes eligible once slot 0 is
    // granted or done, which keeps dispatch in order. When both slots target
    // the same station in one cycle slot 1 needs a second free entry; with
    // only two slots a free count of 3 still yields at most two grants.
    // Flush and reset override everything and force the controller to PAIR.
    always_comb begin
        w_g0        = 1'b0;
        w_g1        = 1'b0;
        w_ok0       = 1'b0;
        w_ok1       = 1'b0;
        w_need1     = 2'd1;
        w_inRdy     = 1'b0;
        w_nextState = r_state;

        case (r_state)
            ST_PAIR: begin
                w_g0    = w_req0 && (w_free0 != 2'd0);
                w_ok0   = w_g0 || w_done0;
                w_need1 = (w_g0 && (w_cls1 == w_cls0)) ? 2'd2 : 2'd1;
                w_g1    = w_ok0 && w_req1 && (w_free1 >= w_need1);
                w_ok1   = w_ok0 && (w_g1 || w_done1);
                if (w_ok0 && w_ok1) begin
                    w_inRdy     = 1'b1;
                    w_nextState = ST_PAIR;
                end else if (w_ok0) begin
                    w_inRdy     = 1'b0;
                    w_nextState = ST_HALF;
                end else begin
                    w_inRdy     = 1'b0;
                    w_nextState = ST_PAIR;
                end
            end
            default: begin
                w_g1    = w_req1 && (w_free1 != 2'd0);
                w_ok1   = w_g1 || w_done1;
                w_inRdy = w_ok1;
                w_nextState = w_ok1 ? ST_PAIR : ST_HALF;
            end
        endcase

        if (flush) begin
            w_g0        = 1'b0;
            w_g1        = 1'b0;
            w_inRdy     = 1'b1;
            w_nextState = ST_PAIR;
        end

        if (rst) begin
            w_g0        = 1'b0;
            w_g1        = 1'b0;
            w_inRdy     = 1'b0;
            w_nextState = ST_PAIR;
        end
    end

    assign w_grant    = {w_g1, w_g0};
    assign bus.grant  = w_grant;
    assign bus.in_rdy = w_inRdy;
    assign stall_cnt  = r_stallCnt;

    // State register. Reset drops any HALF progress so the held pair is
    // re-evaluated from slot 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PAIR;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Stall counter: counts cycles with a valid pair that was not fully
    // consumed, ignoring flush cycles, and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if ((|bus.in_val) && !w_inRdy && !flush) begin
            if (r_stallCnt != {CNT_BITS{1'b1}}) begin
                r_stallCnt <= r_stallCnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameter PIPE_WIDTH, default 2, meaning dispatch slots per cycle; only 2 is supported.
REQ-002 SHALL have parameter CNT_BITS, default 16, meaning stall-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-006 SHALL have port in_val, input, [1:0]: per-slot valid of the decoded pair; slot 0 is older.
REQ-007 SHALL have port in_class, input, 2x[1:0]: per-slot class, 0=ALU, 1=MEM, 2=BR, 3=NONE (nop, needs no entry).
REQ-008 SHALL have port in_rdy, output, 1 bit: the pair is consumed this cycle; upstream holds the pair stable while in_rdy=0.
REQ-009 SHALL have ports alu_free, mem_free and br_free, each input [1:0]: free entries (0..3) in each reservation station, sampled the same cycle.
REQ-010 SHALL have port grant, output, [1:0]: slot i is written into its class station this cycle.
REQ-011 SHALL have port stall_cnt, output, [CNT_BITS-1:0]: count of cycles in which a valid pair was not fully consumed.

Function
REQ-012 SHALL have two states: PAIR (no slot dispatched yet) and HALF (slot 0 already dispatched, slot 1 pending).
REQ-013 SHALL treat a slot as done when it is invalid, or when it is valid with class NONE and it is that slot's turn; a done slot consumes no station entry.
REQ-014 In PAIR, slot 0 SHALL be grantable iff it is valid, its class is not NONE, and its class free count is >=1.
REQ-015 In PAIR, slot 1 SHALL be grantable iff slot 0 is granted or done, slot 1 is valid and not NONE, and its class free count is >= 1 + (slot 0 granted with the same class).
REQ-016 Dispatch SHALL be strictly in order: slot 1 is never granted while slot 0 is neither granted nor done.
REQ-017 In PAIR: if both slots are granted or done, in_rdy=1 and the state stays PAIR; if only slot 0 is granted or done, in_rdy=0 and the state goes to HALF; otherwise in_rdy=0 and the state stays PAIR.
REQ-018 In HALF: grant[0]=0; slot 1 SHALL be granted or done per its own free count (>=1); when it is, in_rdy=1 and the state goes to PAIR, otherwise the state stays HALF.
REQ-019 grant and in_rdy SHALL be combinational from the current state and inputs (zero-cycle latency); the state is the only sequential element besides stall_cnt.
REQ-020 If in_val=2'b00, in_rdy SHALL be 1 and grant SHALL be 0 in both states; in HALF this case returns the state to PAIR.
REQ-021 On a cycle with flush=1: grant=0 and in_rdy=1; the next state is PAIR; stall_cnt is unchanged.
REQ-022 stall_cnt SHALL increment by 1 each cycle in which any in_val bit=1, in_rdy=0 and flush=0; it saturates at all-ones and does not wrap.
REQ-023 A free count of 3 SHALL never allow more than 2 grants per cycle (bounded by PIPE_WIDTH).

Reset
REQ-024 When rst=1 at a clock edge: state becomes PAIR and stall_cnt becomes 0, with priority over flush; outputs while rst=1 SHALL be grant=0 and in_rdy=0.
REQ-025 Reset asserted while in HALF SHALL discard the pending slot-1 progress; after reset the pair is re-evaluated from slot 0.

Verification
REQ-026 Both ALU, alu_free=2 -> grant=11, in_rdy=1, state PAIR.
REQ-027 Both ALU, alu_free=1 -> cycle 1: grant=01, in_rdy=0, state HALF. Cycle 2 with alu_free=1: grant=10, in_rdy=1, state PAIR. stall_cnt=1.
REQ-028 Slot 0 MEM with mem_free=0, slot 1 ALU with alu_free=2 -> grant=00, in_rdy=0 for 3 cycles, stall_cnt=3. Then mem_free=1 -> grant=11.
REQ-029 Slot 0 NONE, slot 1 BR, br_free=0 -> grant=00, state HALF. Then br_free=1 -> grant=10, in_rdy=1.
REQ-030 In HALF, assert flush -> grant=00, in_rdy=1, next state PAIR. Then assert rst mid-stall -> stall_cnt=0, grant=00.
REQ-031 Preload stall_cnt to all-ones minus 1, then hold a stall for 3 cycles -> stall_cnt saturates at 16'hFFFF.
